// File: rtl/alu_nbit_pkg.sv
`default_nettype none
// alu_nbit_pkg: op codes and FSM state encoding shared by the alu_nbit blocks (rev 1.0).
package alu_nbit_pkg;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_SLT = 3'b100;
  localparam logic [2:0] OP_NOR = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_RSV = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage
`default_nettype wire

// File: rtl/alu_nbit_comb.sv
`default_nettype none
// alu_nbit_comb: single-cycle logic/adder unit; MUL and reserved codes yield all-zero outputs (rev 1.0).
module alu_nbit_comb
  import alu_nbit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             overflow
);

  logic             sub;
  logic [WIDTH-1:0] b_x;
  logic [WIDTH:0]   sum;
  logic             ovf;

  // SUB and SLT share the adder as a + ~b + 1.
  assign sub = (op == OP_SUB) || (op == OP_SLT);
  assign b_x = sub ? ~b : b;
  assign sum = {1'b0, a} + {1'b0, b_x} + {{WIDTH{1'b0}}, sub};
  assign ovf = (a[WIDTH-1] == b_x[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);

  always_comb begin
    result   = '0;
    carry    = 1'b0;
    overflow = 1'b0;
    case (op)
      OP_AND: result = a & b;
      OP_OR:  result = a | b;
      OP_NOR: result = ~(a | b);
      OP_ADD, OP_SUB: begin
        result   = sum[WIDTH-1:0];
        carry    = sum[WIDTH];
        overflow = ovf;
      end
      OP_SLT: result = {{(WIDTH-1){1'b0}}, sum[WIDTH-1] ^ ovf};
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_nbit_seq.sv
`default_nettype none
// alu_nbit_seq: handshaked N-bit ALU with registered result (rev 1.0).
// Define ALU_NBIT_MUL_EN to build the multi-cycle unsigned shift-add multiplier.
module alu_nbit_seq
  import alu_nbit_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             carry,
  output logic             overflow,
  output logic             illegal
);

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] c_result;
  logic             c_carry;
  logic             c_ovf;
  logic             accept;
  logic             mul_req;
  logic             last_step;
  logic             illegal_op;

  alu_nbit_comb #(.WIDTH(WIDTH)) u_comb (
    .op       (op),
    .a        (a),
    .b        (b),
    .result   (c_result),
    .carry    (c_carry),
    .overflow (c_ovf)
  );

  assign accept    = (state == S_IDLE) && in_valid;
  assign in_ready  = (state == S_IDLE) && !rst;
  assign out_valid = (state == S_DONE);

`ifdef ALU_NBIT_MUL_EN
  localparam int CW = $clog2(WIDTH);

  logic [CW-1:0]      step;
  logic [WIDTH-1:0]   mcand;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH:0]     psum;
  logic [2*WIDTH-1:0] prod_nx;

  assign mul_req    = (op == OP_MUL);
  assign illegal_op = (op == OP_RSV);
  assign last_step  = (state == S_BUSY) && (step == CW'(WIDTH - 1));

  // Multiplier sits in the low half and shifts out as partial sums enter the top.
  assign psum    = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
  assign prod_nx = {psum, prod[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step  <= '0;
      mcand <= '0;
      prod  <= '0;
    end else if (accept && mul_req) begin
      step  <= '0;
      mcand <= a;
      prod  <= {{WIDTH{1'b0}}, b};
    end else if (state == S_BUSY) begin
      step  <= step + CW'(1);
      prod  <= prod_nx;
    end
  end
`else
  assign mul_req    = 1'b0;
  assign last_step  = 1'b0;
  assign illegal_op = (op == OP_RSV) || (op == OP_MUL);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (in_valid) state_nx = mul_req ? S_BUSY : S_DONE;
      S_BUSY:  if (last_step) state_nx = S_DONE;
      S_DONE:  if (out_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result   <= '0;
      zero     <= 1'b0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      illegal  <= 1'b0;
    end else if (accept && !mul_req) begin
      result   <= c_result;
      zero     <= (c_result == '0);
      carry    <= c_carry;
      overflow <= c_ovf;
      illegal  <= illegal_op;
    end
`ifdef ALU_NBIT_MUL_EN
    else if (last_step) begin
      result   <= prod_nx[WIDTH-1:0];
      zero     <= (prod_nx[WIDTH-1:0] == '0);
      carry    <= 1'b0;
      overflow <= |prod_nx[2*WIDTH-1:WIDTH];
      illegal  <= 1'b0;
    end
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_nbit_seq.sv
`default_nettype none
// tb_alu_nbit_seq: directed vectors for alu_nbit_seq at WIDTH = 8 against a behavioural model.
module tb_alu_nbit_seq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   op = 3'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
  logic         zero;
  logic         carry;
  logic         overflow;
  logic         illegal;

  int errors = 0;
  int checks = 0;

  alu_nbit_seq #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .carry     (carry),
    .overflow  (overflow),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] res;
    logic         z;
    logic         c;
    logic         o;
    logic         ill;
  } exp_t;

  function automatic exp_t ref_alu(input logic [2:0] f, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    int sx, sy, ux, uy, full;
    sx = $signed(x);
    sy = $signed(y);
    ux = x;
    uy = y;
    full = 0;
    e = '0;
    case (f)
      3'd0: e.res = x & y;
      3'd1: e.res = x | y;
      3'd5: e.res = ~(x | y);
      3'd2: begin
        full  = ux + uy;
        e.res = full[W-1:0];
        e.c   = (full > 255);
        e.o   = (sx + sy > 127) || (sx + sy < -128);
      end
      3'd3: begin
        full  = ux + 256 - uy;
        e.res = full[W-1:0];
        e.c   = (full > 255);
        e.o   = (sx - sy > 127) || (sx - sy < -128);
      end
      3'd4: e.res = (sx < sy) ? 8'd1 : 8'd0;
`ifdef ALU_NBIT_MUL_EN
      3'd6: begin
        full  = ux * uy;
        e.res = full[W-1:0];
        e.o   = (full > 255);
      end
`else
      3'd6: e.ill = 1'b1;
`endif
      default: e.ill = 1'b1;
    endcase
    e.z = (e.res == '0);
    return e;
  endfunction

  function automatic int ref_lat(input logic [2:0] f);
`ifdef ALU_NBIT_MUL_EN
    return (f == 3'd6) ? W : 0;
`else
    return (f == 3'd6) ? 0 : 0;
`endif
  endfunction

  // Model: one outstanding op; m_left counts edges until its result is visible.
  logic m_pending = 1'b0;
  int   m_left = 0;
  exp_t m_exp = '0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pending <= 1'b0;
      m_left    <= 0;
    end else if (m_pending) begin
      if (m_left != 0)    m_left <= m_left - 1;
      else if (out_ready) m_pending <= 1'b0;
    end else if (in_valid) begin
      m_exp     <= ref_alu(op, a, b);
      m_left    <= ref_lat(op);
      m_pending <= 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      chk("rst_in_ready", 32'(in_ready), 0);
      chk("rst_out_valid", 32'(out_valid), 0);
      chk("rst_result", 32'(result), 0);
      chk("rst_flags", {28'd0, zero, carry, overflow, illegal}, 0);
    end else begin
      chk("in_ready", 32'(in_ready), 32'(!m_pending));
      chk("out_valid", 32'(out_valid), 32'(m_pending && m_left == 0));
      if (m_pending && m_left == 0) begin
        chk("model_result", 32'(result), 32'(m_exp.res));
        chk("model_flags", {28'd0, zero, carry, overflow, illegal},
            {28'd0, m_exp.z, m_exp.c, m_exp.o, m_exp.ill});
      end
    end
  end

  task automatic issue(input logic [2:0] f, input logic [W-1:0] x, input logic [W-1:0] y, output int lat);
    op = f;
    a = x;
    b = y;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic drain;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic expect_out(input string name, input int lat, input int exp_lat, input logic [W-1:0] res,
                            input logic z, input logic c, input logic o, input logic ill);
    chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({name, "_result"}, 32'(result), 32'(res));
    chk({name, "_flags"}, {28'd0, zero, carry, overflow, illegal}, {28'd0, z, c, o, ill});
  endtask

  initial begin
    int lat;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready_low", 32'(in_ready), 0);
    rst = 1'b0;
    #1;
    chk("release_in_ready", 32'(in_ready), 1);
    @(posedge clk); #1;

    issue(3'd2, 8'h7F, 8'h01, lat);
    expect_out("add_ovf", lat, 0, 8'h80, 1'b0, 1'b0, 1'b1, 1'b0);
    drain();

    issue(3'd3, 8'h05, 8'h05, lat);
    expect_out("sub_zero", lat, 0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    drain();

    issue(3'd4, 8'hFF, 8'h01, lat);
    expect_out("slt_neg", lat, 0, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    drain();

    issue(3'd6, 8'h10, 8'h11, lat);
`ifdef ALU_NBIT_MUL_EN
    expect_out("mul", lat, W, 8'h10, 1'b0, 1'b0, 1'b1, 1'b0);
`else
    expect_out("mul_absent", lat, 0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
`endif
    drain();

    // Backpressure: a competing request must be ignored while the result is held.
    issue(3'd1, 8'hA5, 8'h0F, lat);
    expect_out("or_bp", lat, 0, 8'hAF, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      op = 3'd0;
      a = 8'h00;
      b = 8'h00;
      in_valid = 1'b1;
      @(posedge clk); #1;
      chk("bp_in_ready", 32'(in_ready), 0);
      chk("bp_out_valid", 32'(out_valid), 1);
      chk("bp_result", 32'(result), 32'h AF);
    end
    in_valid = 1'b0;
    drain();
    chk("bp_release_in_ready", 32'(in_ready), 1);
    chk("bp_release_out_valid", 32'(out_valid), 0);

    // Reset during MUL (or in DONE when the multiplier is not built).
    op = 3'd6;
    a = 8'hFF;
    b = 8'hFF;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_out_valid", 32'(out_valid), 0);
    chk("abort_result", 32'(result), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    chk("abort_no_result", 32'(out_valid), 0);
    issue(3'd0, 8'hF0, 8'h3C, lat);
    expect_out("and_after_rst", lat, 0, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0);
    drain();

    issue(3'd7, 8'h12, 8'h34, lat);
    expect_out("reserved", lat, 0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
    drain();

    issue(3'd5, 8'h0F, 8'hF0, lat);
    expect_out("nor_clears_illegal", lat, 0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    drain();

    issue(3'd2, 8'hFF, 8'h01, lat);
    expect_out("add_wrap", lat, 0, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    drain();

    // Consumer ready ahead of time: result is taken on the first DONE cycle.
    out_ready = 1'b1;
    issue(3'd3, 8'h80, 8'h01, lat);
    expect_out("sub_early_ready", lat, 0, 8'h7F, 1'b0, 1'b1, 1'b1, 1'b0);
    @(posedge clk); #1;
    chk("early_ready_in_ready", 32'(in_ready), 1);
    chk("early_ready_out_valid", 32'(out_valid), 0);
    out_ready = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
